feature_reader: RTL and testbench

- Consumer end of the feature datapath. Accepts the signed feature word and one-cycle valid strobe from the ps/ne feature modules.
- Buffers each feature in a small FIFO that the host/controller drains over a request/valid read handshake.
- Runs a consecutive-threshold detection FSM on the captured stream and drives a detect flag to the system controller.

---
 rtl/feature_reader_if.sv | 30 +++
 rtl/feature_reader.sv | 172 +++++++++++++++++
 tb/tb_feature_reader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/feature_reader_if.sv
// Feature-stream write strobe and host read handshake between the feature modules,
// the reader FIFO and the host. rd_ts exists only when FEATURE_READER_TIMESTAMP_EN is defined.
interface feature_reader_if #(
  parameter int unsigned FEAT_WIDTH = 40
);
  logic [FEAT_WIDTH-1:0] feat_in;
  logic                  feat_valid;
  logic                  rd_req;
  logic                  rd_valid;
  logic [FEAT_WIDTH-1:0] rd_data;
`ifdef FEATURE_READER_TIMESTAMP_EN
  logic [15:0]           rd_ts;
`endif

  modport master (
    output feat_in, feat_valid, rd_req,
`ifdef FEATURE_READER_TIMESTAMP_EN
    input  rd_ts,
`endif
    input  rd_valid, rd_data
  );

  modport slave (
    input  feat_in, feat_valid, rd_req,
`ifdef FEATURE_READER_TIMESTAMP_EN
    output rd_ts,
`endif
    output rd_valid, rd_data
  );
endinterface

// File: rtl/feature_reader.sv
// Feature reader: buffers the feature stream in a small FIFO drained by the host and runs a
// consecutive-threshold alarm FSM. FEATURE_READER_TIMESTAMP_EN adds a per-entry feature index.
module feature_reader #(
  parameter int unsigned FEAT_WIDTH = 40,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned HIT_COUNT  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  feature_reader_if.slave       bus,
  input  logic [FEAT_WIDTH-1:0] thresh,
  output logic [ADDR_W:0]       fifo_count,
  output logic                  overflow,
  output logic                  detect
);

  localparam int unsigned CntW = $clog2(HIT_COUNT + 1);
`ifdef FEATURE_READER_TIMESTAMP_EN
  localparam int unsigned EntryW = FEAT_WIDTH + 16;
`else
  localparam int unsigned EntryW = FEAT_WIDTH;
`endif

  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CountMax = (ADDR_W + 1)'(DEPTH);
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);
  localparam logic [CntW-1:0]   CntHit   = CntW'(HIT_COUNT);

  typedef enum logic [1:0] {StIdle, StCount, StAlarm} state_e;

  logic [EntryW-1:0]     mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]       count_q;
  logic                  rd_valid_q;
  logic [FEAT_WIDTH-1:0] rd_data_q;
  logic                  overflow_q;

  state_e                state_q;
  logic [CntW-1:0]       hit_cnt_q, rel_cnt_q;
  logic [CntW-1:0]       hit_inc, rel_inc;
  logic                  detect_q;

  logic                  full, empty, push, pop, above;
  logic [EntryW-1:0]     wr_entry;

  assign full  = (count_q == CountMax);
  assign empty = (count_q == '0);
  assign pop   = bus.rd_req && !empty;
  // A pop on a full FIFO frees the slot the same-cycle write lands in.
  assign push  = bus.feat_valid && (!full || pop);
  assign above = $signed(bus.feat_in) > $signed(thresh);

  assign hit_inc = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + CntOne;
  assign rel_inc = (rel_cnt_q == '1) ? rel_cnt_q : rel_cnt_q + CntOne;

`ifdef FEATURE_READER_TIMESTAMP_EN
  logic [15:0] idx_q;
  logic [15:0] rd_ts_q;

  assign wr_entry = {idx_q, bus.feat_in};

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q   <= '0;
      rd_ts_q <= '0;
    end else begin
      if (bus.feat_valid) idx_q <= idx_q + 16'd1;
      if (pop)            rd_ts_q <= mem_q[rd_ptr_q][EntryW-1:FEAT_WIDTH];
    end
  end

  assign bus.rd_ts = rd_ts_q;
`else
  assign wr_entry = bus.feat_in;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrOne;
        rd_data_q <= mem_q[rd_ptr_q][FEAT_WIDTH-1:0];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CountOne;
        2'b01:   count_q <= count_q - CountOne;
        default: count_q <= count_q;
      endcase
      if (bus.feat_valid && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      hit_cnt_q <= '0;
      rel_cnt_q <= '0;
      detect_q  <= 1'b0;
    end else if (bus.feat_valid) begin
      case (state_q)
        StIdle: begin
          if (above) begin
            if (HIT_COUNT == 1) begin
              state_q   <= StAlarm;
              hit_cnt_q <= '0;
              rel_cnt_q <= '0;
              detect_q  <= 1'b1;
            end else begin
              state_q   <= StCount;
              hit_cnt_q <= CntOne;
            end
          end else begin
            hit_cnt_q <= '0;
          end
        end
        StCount: begin
          if (above) begin
            if (hit_inc == CntHit) begin
              state_q   <= StAlarm;
              hit_cnt_q <= '0;
              rel_cnt_q <= '0;
              detect_q  <= 1'b1;
            end else begin
              hit_cnt_q <= hit_inc;
            end
          end else begin
            state_q   <= StIdle;
            hit_cnt_q <= '0;
          end
        end
        StAlarm: begin
          if (above) begin
            rel_cnt_q <= '0;
          end else if (rel_inc == CntHit) begin
            state_q   <= StIdle;
            rel_cnt_q <= '0;
            detect_q  <= 1'b0;
          end else begin
            rel_cnt_q <= rel_inc;
          end
        end
        default: begin
          state_q   <= StIdle;
          hit_cnt_q <= '0;
          rel_cnt_q <= '0;
          detect_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign detect       = detect_q;

endmodule

// File: tb/tb_feature_reader.sv
// Directed self-checking bench for feature_reader; checks FIFO, overflow, detect FSM and reset,
// plus feature indices when FEATURE_READER_TIMESTAMP_EN is defined.
module tb_feature_reader;
  localparam int unsigned FW = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] thresh;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic          detect;

  int total = 0;
  int bad   = 0;

  feature_reader_if #(.FEAT_WIDTH(FW)) bus ();

  feature_reader #(
    .FEAT_WIDTH(FW),
    .DEPTH     (4),
    .ADDR_W    (2),
    .HIT_COUNT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .thresh    (thresh),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .detect    (detect)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] feat(input int v);
    return FW'(v);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs set before the call take effect at the next rising edge; outputs sampled 1 after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int v);
    bus.feat_valid = 1'b1;
    bus.feat_in    = feat(v);
    step();
    bus.feat_valid = 1'b0;
  endtask

  int wr3 [3]   = '{10, -5, 7};
  int det_v [9] = '{150, 200, 50, 120, 130, 140, 10, 20, 30};
  bit det_e [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};

  initial begin
    rst            = 1'b0;
    thresh         = feat(1000);
    bus.feat_in    = '0;
    bus.feat_valid = 1'b0;
    bus.rd_req     = 1'b0;
    step();
    step();
    check("rst_count", fifo_count, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_detect", detect, 0);
    rst = 1'b1;
    step();

    // Spaced writes then single reads.
    for (int i = 0; i < 3; i++) begin
      write(wr3[i]);
      check($sformatf("wr_count%0d", i), fifo_count, i + 1);
      step(); step(); step();
    end
    for (int i = 0; i < 3; i++) begin
      bus.rd_req = 1'b1;
      step();
      bus.rd_req = 1'b0;
      check($sformatf("rd_valid%0d", i), bus.rd_valid, 1);
      check($sformatf("rd_data%0d", i), bus.rd_data, feat(wr3[i]));
      step();
      check($sformatf("rd_pulse%0d", i), bus.rd_valid, 0);
    end
    check("drain_count", fifo_count, 0);

    // Overflow: fifth write is dropped, flag is sticky.
    for (int i = 1; i <= 5; i++) write(i);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    bus.rd_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("ovf_rd%0d", i), bus.rd_data, feat(i));
      check($sformatf("ovf_rv%0d", i), bus.rd_valid, 1);
    end
    bus.rd_req = 1'b0;
    step();
    check("ovf_rv_end", bus.rd_valid, 0);
    check("ovf_count_end", fifo_count, 0);
    check("ovf_sticky", overflow, 1);

    rst = 1'b0;
    step();
    rst = 1'b1;

    // Full FIFO with simultaneous push and pop.
    for (int i = 11; i <= 14; i++) write(i);
    check("full_count", fifo_count, 4);
    bus.rd_req     = 1'b1;
    bus.feat_valid = 1'b1;
    bus.feat_in    = feat(9);
    step();
    bus.feat_valid = 1'b0;
    check("full_rw_data", bus.rd_data, feat(11));
    check("full_rw_count", fifo_count, 4);
    check("full_rw_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("full_drain%0d", i), bus.rd_data, feat(i == 3 ? 9 : 12 + i));
    end
    bus.rd_req = 1'b0;
    step();
    check("full_drain_count", fifo_count, 0);

    // Detection: 50 breaks the run, 140 completes it, 10/20/30 release.
    thresh = feat(100);
    for (int i = 0; i < 9; i++) begin
      write(det_v[i]);
      check($sformatf("det%0d", i), detect, 64'(det_e[i]));
    end
    check("det_ovf", overflow, 1);

    // Drain 150,200,50,120, then read on empty.
    bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("det_last", bus.rd_data, feat(120));
    step();
    check("empty_rv", bus.rd_valid, 0);
    check("empty_count", fifo_count, 0);
    check("empty_hold", bus.rd_data, feat(120));
    bus.rd_req = 1'b0;

    // Mid-operation reset with a pending read.
    write(150); write(160); write(170);
    check("pre_rst_det", detect, 1);
    bus.rd_req = 1'b1;
    step();
    check("pre_rst_count", fifo_count, 2);
    rst = 1'b0;
    step();
    bus.rd_req = 1'b0;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_det", detect, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_rv", bus.rd_valid, 0);
    rst = 1'b1;
    step();

`ifdef FEATURE_READER_TIMESTAMP_EN
    thresh = feat(1000);
    check("ts_rst", bus.rd_ts, 0);
    for (int i = 0; i < 6; i++) write(100 + i);
    bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("ts%0d", i), bus.rd_ts, i);
      check($sformatf("ts_data%0d", i), bus.rd_data, feat(100 + i));
    end
    bus.rd_req = 1'b0;
    write(77);
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("ts_next", bus.rd_ts, 6);
    check("ts_next_data", bus.rd_data, feat(77));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
